// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
`timescale 1ns/1ps
package ifetch_pkg;

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_PRESENT = 2'd1,
        S_HALT    = 2'd2
    } state_t;

    localparam int unsigned ADDR_W  = 64;
    localparam int unsigned INSTR_W = 32;
    localparam logic [ADDR_W-1:0] PC_INCR = 64'd4;

endpackage

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, waits RD_LATENCY cycles for imem, presents {instr, pc}
// to decode over valid/ready, follows taken-branch redirects, halts past PC_LIMIT.
`timescale 1ns/1ps
module instr_fetch_unit
    import ifetch_pkg::*;
#(
    parameter int unsigned       RD_LATENCY = 2,
    parameter logic [ADDR_W-1:0] PC_LIMIT   = 64'h58
) (
    input  logic               CLK,
    input  logic               Reset_L,
    input  logic [ADDR_W-1:0]  startPC,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               if_valid,
    input  logic               if_ready,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc,
    output logic               fetch_halted
);

    localparam int unsigned      CNT_W    = $clog2(RD_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LATENCY - 1);

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   pc, pc_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [INSTR_W-1:0]  instr_nxt;
    logic [ADDR_W-1:0]   ipc_nxt;

    always_ff @(posedge CLK) begin
        if (!Reset_L) begin
            state    <= S_FETCH;
            pc       <= startPC;
            cnt      <= '0;
            if_instr <= '0;
            if_pc    <= '0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            cnt      <= cnt_nxt;
            if_instr <= instr_nxt;
            if_pc    <= ipc_nxt;
        end
    end

    // Redirect wins over every normal transition, including a same-edge accept.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        cnt_nxt   = cnt;
        instr_nxt = if_instr;
        ipc_nxt   = if_pc;
        if (redirect_valid) begin
            state_nxt = S_FETCH;
            pc_nxt    = {redirect_pc[ADDR_W-1:2], 2'b00};
            cnt_nxt   = '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (pc >= PC_LIMIT) begin
                        state_nxt = S_HALT;
                    end else if (cnt == CNT_LAST) begin
                        instr_nxt = imem_data;
                        ipc_nxt   = pc;
                        cnt_nxt   = '0;
                        state_nxt = S_PRESENT;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                S_PRESENT: begin
                    if (if_ready) begin
                        pc_nxt    = pc + PC_INCR;
                        state_nxt = S_FETCH;
                    end
                end
                S_HALT: begin
                    state_nxt = S_HALT;
                end
                default: begin
                    state_nxt = S_FETCH;
                end
            endcase
        end
    end

    assign imem_addr    = pc;
    assign if_valid     = (state == S_PRESENT);
    assign fetch_halted = (state == S_HALT);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: transaction-level reference model plus directed vectors.
`timescale 1ns/1ps
module tb_instr_fetch_unit;

    localparam int unsigned  RD_LAT = 2;
    localparam logic [63:0]  LIMIT  = 64'h58;

    logic        CLK = 1'b0;
    logic        Reset_L = 1'b0;
    logic [63:0] startPC = 64'h0;
    logic [63:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = 64'h0;
    logic        if_valid;
    logic        if_ready = 1'b1;
    logic [31:0] if_instr;
    logic [63:0] if_pc;
    logic        fetch_halted;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    instr_fetch_unit #(.RD_LATENCY(RD_LAT), .PC_LIMIT(LIMIT)) dut (
        .CLK(CLK), .Reset_L(Reset_L), .startPC(startPC),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_ready(if_ready),
        .if_instr(if_instr), .if_pc(if_pc), .fetch_halted(fetch_halted)
    );

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        case (a)
            64'h000: mem_word = 32'hF84003E9;
            64'h004: mem_word = 32'hF84083EA;
            64'h010: mem_word = 32'hF84203ED;
            64'h014: mem_word = 32'hAA0B014A;
            64'h018: mem_word = 32'h8A0A018C;
            64'h028: mem_word = 32'h17FFFFFD;
            64'h054: mem_word = 32'hF84283EA;
            default: mem_word = 32'h91000000 | a[31:0];
        endcase
    endfunction

    assign imem_data = mem_word(imem_addr);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an instruction becomes visible after RD_LAT edges of waiting,
    // stays until consumed, and the PC moves only on accept, redirect or reset.
    bit          started = 1'b0;
    int          m_left;
    logic [63:0] m_pc;
    bit          m_valid, m_halt;
    logic [31:0] m_instr;
    logic [63:0] m_ipc;

    always @(posedge CLK) begin
        if (!Reset_L) begin
            started = 1'b1;
            m_pc = startPC; m_left = RD_LAT; m_valid = 0; m_halt = 0;
            m_instr = '0; m_ipc = '0;
        end else if (redirect_valid) begin
            m_pc = redirect_pc & ~64'h3; m_left = RD_LAT; m_valid = 0; m_halt = 0;
        end else if (m_halt) begin
            m_halt = 1;
        end else if (m_valid) begin
            if (if_ready) begin
                m_pc = m_pc + 64'd4; m_valid = 0; m_left = RD_LAT;
            end
        end else if (m_pc >= LIMIT) begin
            m_halt = 1;
        end else begin
            m_left--;
            if (m_left == 0) begin
                m_valid = 1; m_instr = mem_word(m_pc); m_ipc = m_pc;
            end
        end
    end

    always @(negedge CLK) begin
        if (started) begin
            chk("imem_addr", imem_addr, m_pc);
            chk("if_valid", 64'(if_valid), 64'(m_valid));
            chk("fetch_halted", 64'(fetch_halted), 64'(m_halt));
            chk("if_instr", 64'(if_instr), 64'(m_instr));
            chk("if_pc", if_pc, m_ipc);
        end
    end

    // Number of handshakes seen per word address in the program region.
    int consumed [0:31];
    initial for (int i = 0; i < 32; i++) consumed[i] = 0;
    always @(posedge CLK)
        if (Reset_L && if_valid && if_ready) consumed[if_pc[6:2]]++;

    task automatic step(input int n);
        repeat (n) begin
            @(negedge CLK);
            #1;
        end
    endtask

    // Accept presentations one at a time until the target PC is on the outputs, then stall it.
    task automatic advance_to(input logic [63:0] target);
        bit found = 0;
        for (int n = 0; n < 300 && !found; n++) begin
            if (if_valid && if_pc == target) begin
                found = 1;
            end else begin
                if_ready = if_valid;
                step(1);
            end
        end
        if_ready = 1'b0;
        chk("advance_to_reached", 64'(found), 64'd1);
    endtask

    initial begin
        // Cold start
        Reset_L = 1'b0; startPC = 64'h0; if_ready = 1'b1;
        step(2);
        Reset_L = 1'b1;
        step(1);
        chk("cold_valid_early", 64'(if_valid), 64'd0);
        step(1);
        chk("cold_valid", 64'(if_valid), 64'd1);
        chk("cold_instr0", 64'(if_instr), 64'hF84003E9);
        chk("cold_pc0", if_pc, 64'h0);
        step(3);
        chk("cold_instr1", 64'(if_instr), 64'hF84083EA);
        chk("cold_pc1", if_pc, 64'h4);

        // Back-pressure at 0x014
        advance_to(64'h14);
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("bp_instr", 64'(if_instr), 64'hAA0B014A);
            chk("bp_pc", if_pc, 64'h14);
            chk("bp_addr", imem_addr, 64'h14);
            chk("bp_valid", 64'(if_valid), 64'd1);
        end
        if_ready = 1'b1;
        step(1);
        if_ready = 1'b0;
        chk("bp_release_addr", imem_addr, 64'h18);
        step(2);
        chk("bp_next_instr", 64'(if_instr), 64'h8A0A018C);
        chk("bp_next_pc", if_pc, 64'h18);

        // Redirect one cycle into fetch of 0x020, misaligned target
        advance_to(64'h1C);
        if_ready = 1'b1;
        step(1);
        if_ready = 1'b0;
        step(1);
        chk("rd_fetch_addr", imem_addr, 64'h20);
        redirect_valid = 1'b1; redirect_pc = 64'h2A;
        step(1);
        redirect_valid = 1'b0;
        chk("rd_addr", imem_addr, 64'h28);
        chk("rd_no_valid", 64'(if_valid), 64'd0);
        step(1);
        chk("rd_wait_valid", 64'(if_valid), 64'd0);
        step(1);
        chk("rd_instr", 64'(if_instr), 64'h17FFFFFD);
        chk("rd_pc", if_pc, 64'h28);
        chk("rd_no_0x20", 64'(consumed[8]), 64'd0);

        // Accept and redirect on the same edge
        if_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h1C;
        step(1);
        if_ready = 1'b0; redirect_valid = 1'b0;
        chk("sim_addr", imem_addr, 64'h1C);
        chk("sim_valid", 64'(if_valid), 64'd0);
        chk("sim_once_0x28", 64'(consumed[10]), 64'd1);

        // Run off the end of the program
        advance_to(64'h54);
        chk("halt_last_instr", 64'(if_instr), 64'hF84283EA);
        if_ready = 1'b1;
        step(1);
        chk("halt_pc", imem_addr, 64'h58);
        chk("halt_not_yet", 64'(fetch_halted), 64'd0);
        step(1);
        chk("halt_set", 64'(fetch_halted), 64'd1);
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk("halt_valid", 64'(if_valid), 64'd0);
            chk("halt_pc_frozen", imem_addr, 64'h58);
        end
        if_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 64'h0;
        step(1);
        redirect_valid = 1'b0;
        chk("unhalt_flag", 64'(fetch_halted), 64'd0);
        chk("unhalt_addr", imem_addr, 64'h0);
        step(2);
        chk("unhalt_instr", 64'(if_instr), 64'hF84003E9);
        chk("unhalt_valid", 64'(if_valid), 64'd1);

        // Reset while presenting 0x00C
        advance_to(64'h0C);
        startPC = 64'h10; Reset_L = 1'b0;
        step(1);
        Reset_L = 1'b1;
        chk("rst_valid", 64'(if_valid), 64'd0);
        chk("rst_instr", 64'(if_instr), 64'h0);
        chk("rst_pc", if_pc, 64'h0);
        chk("rst_addr", imem_addr, 64'h10);
        step(2);
        chk("rst_next_instr", 64'(if_instr), 64'hF84203ED);
        chk("rst_next_pc", if_pc, 64'h10);
        step(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: simulation did not finish, expected completion before 200000");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
